wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares one slave port among up to N masters, for example the on-chip RAM shared by the CPU instruction bus, CPU data bus and debug master.
- Grant is held for the whole `cyc` assertion, so B3 incrementing bursts (cti=010) stay atomic.
- A per-access watchdog returns `err` to the granted master if the slave never responds.
- Sits between the masters and one slave port of the system interconnect.

---
 rtl/wb_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: one slave port shared by num_masters
// masters, grant held for the whole cyc, watchdog err on a silent slave.
module wb_rr_arbiter #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int num_masters    = 3,
  parameter int timeout_cycles = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [num_masters*aw-1:0]     wbm_adr_i,
  input  logic [num_masters*dw-1:0]     wbm_dat_i,
  input  logic [num_masters*dw/8-1:0]   wbm_sel_i,
  input  logic [num_masters-1:0]        wbm_we_i,
  input  logic [num_masters-1:0]        wbm_cyc_i,
  input  logic [num_masters-1:0]        wbm_stb_i,
  input  logic [num_masters*3-1:0]      wbm_cti_i,
  input  logic [num_masters*2-1:0]      wbm_bte_i,
  output logic [dw-1:0]                 wbm_dat_o,
  output logic [num_masters-1:0]        wbm_ack_o,
  output logic [num_masters-1:0]        wbm_err_o,
  output logic [num_masters-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [num_masters-1:0]        grant_o
);

  localparam int IW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int TW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam int SW = dw / 8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [num_masters-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_last, w_last_nxt;
  logic [TW-1:0]          r_tcnt, w_tcnt_nxt;

  logic          w_busy;
  logic          w_gcyc;
  logic          w_gstb;
  logic          w_resp;
  logic          w_fire;
  logic          w_found;
  logic [IW-1:0] w_pick;

  assign w_busy    = (r_state == S_BUSY);
  assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign grant_o   = r_grant;
  assign wbm_dat_o = wbs_dat_i;

  // r_last holds the granted index for as long as we are BUSY
  always_comb begin
    w_gcyc = 1'b0;
    w_gstb = 1'b0;
    for (int k = 0; k < num_masters; k++) begin
      if (w_busy && r_last == IW'(k)) begin
        w_gcyc = wbm_cyc_i[k];
        w_gstb = wbm_stb_i[k];
      end
    end
  end

  assign w_fire = (timeout_cycles != 0) && w_gstb && !w_resp &&
                  (r_tcnt == TW'(timeout_cycles));

  // first requester after the last winner, wrapping
  always_comb begin
    int j;
    w_found = 1'b0;
    w_pick  = r_last;
    j       = 0;
    for (int i = 1; i <= num_masters; i++) begin
      j = int'(r_last) + i;
      if (j >= num_masters) j = j - num_masters;
      if (!w_found && wbm_cyc_i[IW'(j)]) begin
        w_found = 1'b1;
        w_pick  = IW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt         = S_BUSY;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_last_nxt          = w_pick;
        end
      end
      S_BUSY: begin
        if (!w_gcyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (timeout_cycles == 0 || !w_gstb || w_resp || w_fire)
      w_tcnt_nxt = '0;
    else
      w_tcnt_nxt = r_tcnt + 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IW'(num_masters - 1);
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int k = 0; k < num_masters; k++) begin
      if (w_busy && r_last == IW'(k)) begin
        wbs_adr_o    = wbm_adr_i[k*aw +: aw];
        wbs_dat_o    = wbm_dat_i[k*dw +: dw];
        wbs_sel_o    = wbm_sel_i[k*SW +: SW];
        wbs_we_o     = wbm_we_i[k];
        wbs_cyc_o    = wbm_cyc_i[k];
        wbs_stb_o    = wbm_stb_i[k] & ~w_fire;
        wbs_cti_o    = wbm_cti_i[k*3 +: 3];
        wbs_bte_o    = wbm_bte_i[k*2 +: 2];
        wbm_ack_o[k] = wbs_ack_i;
        wbm_err_o[k] = wbs_err_i | w_fire;
        wbm_rty_o[k] = wbs_rty_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, corner sequences and a
// randomized run against an ownership/priority reference model.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk;
  logic wb_rst_i;

  logic [NM-1:0] m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [NM];
  logic [DW-1:0] m_dat [NM];
  logic [3:0]    m_sel [NM];
  logic [2:0]    m_cti [NM];
  logic [1:0]    m_bte [NM];

  logic [NM*AW-1:0] adr_f;
  logic [NM*DW-1:0] dat_f;
  logic [NM*4-1:0]  sel_f;
  logic [NM*3-1:0]  cti_f;
  logic [NM*2-1:0]  bte_f;

  logic [DW-1:0] wbm_dat_o;
  logic [NM-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;

  logic [DW-1:0] s_dat;
  logic s_ack_man, s_err, s_rty, auto_en, auto_ack, s_ack;

  int n_chk = 0;
  int n_pass = 0;

  always_comb begin
    for (int k = 0; k < NM; k++) begin
      adr_f[k*AW +: AW] = m_adr[k];
      dat_f[k*DW +: DW] = m_dat[k];
      sel_f[k*4 +: 4]   = m_sel[k];
      cti_f[k*3 +: 3]   = m_cti[k];
      bte_f[k*2 +: 2]   = m_bte[k];
    end
  end

  // registered slave: acks the cycle after it sees a strobe
  assign s_ack = s_ack_man | (auto_en & auto_ack);
  always @(posedge clk)
    auto_ack <= auto_en & wbs_cyc_o & wbs_stb_o & ~auto_ack;

  wb_rr_arbiter #(
    .dw(DW), .aw(AW), .num_masters(NM), .timeout_cycles(TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .wbm_adr_i(adr_f),
    .wbm_dat_i(dat_f),
    .wbm_sel_i(sel_f),
    .wbm_we_i (m_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(cti_f),
    .wbm_bte_i(bte_f),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [87:0] all_outs();
    return {grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
            wbs_sel_o, wbs_cti_o, wbs_bte_o, wbm_ack_o, wbm_err_o, wbm_rty_o};
  endfunction

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack_man = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 32'h5a5a_0001;
    auto_en = 1'b0;
    for (int k = 0; k < NM; k++) begin
      m_adr[k] = 32'h100 * k;
      m_dat[k] = 32'hd000_0000 + k;
      m_sel[k] = 4'hf;
      m_cti[k] = 3'b000;
      m_bte[k] = 2'b00;
    end
  endtask

  task automatic reset_dut();
    wb_rst_i = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic        ack;
    logic        err;
    logic        rty;
    logic [2:0]  e_gnt;
    logic        e_cyc;
    logic        e_stb;
    logic [2:0]  e_ack;
    logic [2:0]  e_err;
    logic [2:0]  e_rty;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl [12];

  logic [2:0] exp_order [6];
  logic [2:0] ackd, prev_g, e_ack, e_err, e_rty, e_gnt;
  logic [75:0] e_bus;
  logic [NM-1:0] mb, resp_seen, err_seen, just_done;
  int beats [NM];
  int n_g, gap, ack0, ack2, own, mlast, wcnt, r, c;
  logic resp, fire, found;

  initial begin
    tbl[0]  = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h0};
    tbl[1]  = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1,
                3'b000, 3'b000, 3'b000, 32'h100};
    tbl[2]  = '{3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1,
                3'b000, 3'b000, 3'b000, 32'h100};
    tbl[3]  = '{3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1,
                3'b010, 3'b000, 3'b000, 32'h100};
    tbl[4]  = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h100};
    tbl[5]  = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h0};
    tbl[6]  = '{3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h0};
    tbl[7]  = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h0};
    tbl[8]  = '{3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b1,
                3'b000, 3'b000, 3'b100, 32'h200};
    tbl[9]  = '{3'b100, 3'b100, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1,
                3'b000, 3'b100, 3'b000, 32'h200};
    tbl[10] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h200};
    tbl[11] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0,
                3'b000, 3'b000, 3'b000, 32'h0};
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    exp_order[3] = 3'b001; exp_order[4] = 3'b010; exp_order[5] = 3'b100;

    // outputs held at zero during reset even with active inputs
    wb_rst_i = 1'b1;
    idle_inputs();
    m_cyc = 3'b111; m_stb = 3'b111; s_ack_man = 1'b1;
    @(negedge clk);
    chk("reset outputs", all_outs(), '0);

    // vector table: single access from m1, idle responses, m2 rty/err
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      s_ack_man = tbl[i].ack; s_err = tbl[i].err; s_rty = tbl[i].rty;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), grant_o, tbl[i].e_gnt);
      chk($sformatf("tbl%0d slave", i), {wbs_cyc_o, wbs_stb_o, wbs_adr_o},
          {tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_adr});
      chk($sformatf("tbl%0d resp", i), {wbm_ack_o, wbm_err_o, wbm_rty_o},
          {tbl[i].e_ack, tbl[i].e_err, tbl[i].e_rty});
      step();
    end

    // fairness: all three keep re-requesting single beats
    reset_dut();
    auto_en = 1'b1;
    ackd = '0; n_g = 0; gap = 0; prev_g = '0;
    for (int cy = 0; cy < 40; cy++) begin
      m_cyc = ~ackd; m_stb = ~ackd;
      @(negedge clk);
      ackd = wbm_ack_o;
      if (grant_o == 3'b000) gap++;
      else if (grant_o != prev_g) begin
        if (n_g > 0) chk($sformatf("rr gap %0d", n_g), gap, 1);
        if (n_g < 6) chk($sformatf("rr order %0d", n_g), grant_o, exp_order[n_g]);
        n_g++;
        gap = 0;
      end
      prev_g = grant_o;
      step();
    end
    chk("rr enough grants", (n_g >= 6), 1);

    // m0 4-beat incrementing burst while m2 waits
    reset_dut();
    m_cyc = 3'b101; m_stb = 3'b101; m_cti[0] = 3'b010;
    ack0 = 0; ack2 = 0;
    for (int cy = 0; cy < 8; cy++) begin
      s_ack_man = (cy >= 1 && cy <= 4);
      if (cy == 4) m_cti[0] = 3'b111;
      if (cy >= 5) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
      @(negedge clk);
      if (cy < 7) begin
        if (wbm_ack_o[0]) ack0++;
        if (wbm_ack_o[2]) ack2++;
      end
      if (cy == 1) chk("burst cti", wbs_cti_o, 3'b010);
      if (cy == 5) chk("burst hold grant", grant_o, 3'b001);
      if (cy == 6) chk("burst idle gap", grant_o, 3'b000);
      if (cy == 7) chk("burst m2 granted", grant_o, 3'b100);
      step();
    end
    chk("burst m0 acks", ack0, 4);
    chk("burst m2 acks", ack2, 0);

    // watchdog: silent slave, then a slave acking on the limit cycle
    reset_dut();
    m_cyc = 3'b010; m_stb = 3'b010;
    for (int cy = 0; cy < 7; cy++) begin
      if (cy == 6) begin m_cyc = '0; m_stb = '0; end
      @(negedge clk);
      if (cy >= 1 && cy <= 4)
        chk($sformatf("to wait %0d", cy), {wbs_stb_o, wbm_err_o}, {1'b1, 3'b000});
      if (cy == 5) chk("to fire", {wbs_stb_o, wbm_err_o}, {1'b0, 3'b010});
      if (cy == 6) chk("to single pulse", wbm_err_o, 3'b000);
      step();
    end
    m_cyc = 3'b010; m_stb = 3'b010;
    for (int cy = 0; cy < 7; cy++) begin
      s_ack_man = (cy == 5);
      if (cy == 6) begin m_cyc = '0; m_stb = '0; end
      @(negedge clk);
      if (cy >= 1 && cy <= 4)
        chk($sformatf("to2 wait %0d", cy), wbm_err_o, 3'b000);
      if (cy == 5)
        chk("to2 ack wins", {wbs_stb_o, wbm_ack_o, wbm_err_o},
            {1'b1, 3'b010, 3'b000});
      if (cy == 6) chk("to2 no late err", wbm_err_o, 3'b000);
      step();
    end

    // asynchronous reset in the middle of an m1 burst
    reset_dut();
    m_cyc = 3'b010; m_stb = 3'b010; m_cti[1] = 3'b010;
    m_we = 3'b010; m_adr[1] = 32'h0000_0104;
    @(negedge clk);
    step();
    s_ack_man = 1'b1;
    @(negedge clk);
    chk("rst burst granted", grant_o, 3'b010);
    step();
    step();
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("rst async outputs", all_outs(), '0);
    m_cyc = 3'b110; m_stb = 3'b110; s_ack_man = 1'b0;
    @(posedge clk);
    #3;
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("rst release idle", grant_o, 3'b000);
    step();
    @(negedge clk);
    chk("rst m1 first", grant_o, 3'b010);

    // randomized traffic against the ownership model
    reset_dut();
    own = -1; mlast = NM - 1; wcnt = 0;
    mb = '0; resp_seen = '0; err_seen = '0;
    for (int k = 0; k < NM; k++) beats[k] = 0;
    for (int cy = 0; cy < 600; cy++) begin
      for (int k = 0; k < NM; k++) begin
        just_done[k] = 1'b0;
        if (mb[k] && resp_seen[k]) begin
          beats[k]--;
          if (err_seen[k] || beats[k] == 0) begin
            mb[k] = 1'b0;
            just_done[k] = 1'b1;
          end
        end
        if (!mb[k] && !just_done[k] && $urandom_range(3) == 0) begin
          mb[k]    = 1'b1;
          beats[k] = int'($urandom_range(4, 1));
          m_adr[k] = $urandom;
          m_dat[k] = $urandom;
          m_we[k]  = 1'($urandom_range(1));
          m_sel[k] = 4'($urandom);
          m_cti[k] = (beats[k] > 1) ? 3'b010 : 3'b000;
          m_bte[k] = 2'($urandom);
        end
        m_cyc[k] = mb[k];
        m_stb[k] = mb[k] && ($urandom_range(7) != 0);
      end
      r = int'($urandom_range(15));
      s_ack_man = (r < 7); s_err = (r == 7); s_rty = (r == 8);
      s_dat = $urandom;
      @(negedge clk);
      resp = s_ack_man | s_err | s_rty;
      fire = (own >= 0) && m_stb[own] && (wcnt == TO) && !resp;
      e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_bus = '0;
      if (own >= 0) begin
        e_gnt[own] = 1'b1;
        e_ack[own] = s_ack_man;
        e_err[own] = s_err | fire;
        e_rty[own] = s_rty;
        e_bus = {m_cyc[own], m_stb[own] & ~fire, m_we[own], m_adr[own],
                 m_dat[own], m_sel[own], m_cti[own], m_bte[own]};
      end
      chk($sformatf("rnd%0d grant", cy), grant_o, e_gnt);
      chk($sformatf("rnd%0d resp", cy), {wbm_ack_o, wbm_err_o, wbm_rty_o},
          {e_ack, e_err, e_rty});
      chk($sformatf("rnd%0d slave bus", cy),
          {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
           wbs_sel_o, wbs_cti_o, wbs_bte_o}, e_bus);
      chk($sformatf("rnd%0d rdata", cy), wbm_dat_o, s_dat);
      resp_seen = e_ack | e_err | e_rty;
      err_seen  = e_err;
      if (own < 0) begin
        wcnt = 0;
        found = 1'b0;
        for (int i = 1; i <= NM; i++) begin
          c = (mlast + i) % NM;
          if (!found && m_cyc[c]) begin
            found = 1'b1;
            own = c;
            mlast = c;
          end
        end
      end else begin
        if (!m_stb[own] || resp || fire) wcnt = 0;
        else wcnt++;
        if (!m_cyc[own]) own = -1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
